// File: rtl/fetch_stage.sv
// fetch_stage: IF stage plus IF/ID pipeline register of a 5-stage RV32I pipeline.
// Holds the fetch PC, forms PC+4, accepts EX redirects, reads instruction memory
// and registers {instr, pc, pc+4, valid} toward decode.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   StallF / StallD     hold PCF / hold the IF/ID register
//   FlushD              load a bubble into IF/ID (wins over StallD)
//   PCSrcE, PCTargetE   redirect request and target from EX
//   ImemReady, ImemRdata  IMEM handshake and combinational read data for PCF
//   PCF                 registered fetch address to IMEM
//   InstrD, PCD, PCPlus4D, ValidD  registered IF/ID contents
module fetch_stage #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   StallF,
  input  logic                   StallD,
  input  logic                   FlushD,
  input  logic                   PCSrcE,
  input  logic [ADDR_WIDTH-1:0]  PCTargetE,
  input  logic                   ImemReady,
  input  logic [INSTR_WIDTH-1:0] ImemRdata,
  output logic [ADDR_WIDTH-1:0]  PCF,
  output logic [INSTR_WIDTH-1:0] InstrD,
  output logic [ADDR_WIDTH-1:0]  PCD,
  output logic [ADDR_WIDTH-1:0]  PCPlus4D,
  output logic                   ValidD
);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  pc_plus4;
    logic                   valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] pc_plus4_f;
  logic [ADDR_WIDTH-1:0] target_aligned;
  ifid_t                 ifid_q;
  ifid_t                 ifid_d;

  // Low target bits are discarded by alignment; keep them visibly consumed.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^PCTargetE[1:0];

  // Sequential increment wraps silently at the top of the address space.
  assign pc_plus4_f     = pc_q + ADDR_WIDTH'(4);
  assign target_aligned = {PCTargetE[ADDR_WIDTH-1:2], 2'b00};

  // Next fetch PC: redirect beats stall and IMEM wait.
  always_comb begin
    pc_d = pc_q;
    if (PCSrcE) begin
      pc_d = target_aligned;
    end else if (!StallF && ImemReady) begin
      pc_d = pc_plus4_f;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Next IF/ID contents: flush, then stall, then IMEM-not-ready bubble, then load.
  always_comb begin
    ifid_d = ifid_q;
    if (FlushD) begin
      ifid_d = BUBBLE;
    end else if (StallD) begin
      ifid_d = ifid_q;
    end else if (!ImemReady) begin
      ifid_d = BUBBLE;
    end else begin
      ifid_d.instr    = ImemRdata;
      ifid_d.pc       = pc_q;
      ifid_d.pc_plus4 = pc_plus4_f;
      ifid_d.valid    = 1'b1;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q <= BUBBLE;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign PCF      = pc_q;
  assign InstrD   = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCPlus4D = ifid_q.pc_plus4;
  assign ValidD   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        ImemReady;
  logic [31:0] ImemRdata;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ImemReady(ImemReady), .ImemRdata(ImemRdata),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  // Instruction memory contents: a fixed, address-dependent pattern.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  assign ImemRdata = imem(PCF);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 32'h0; ImemReady = 1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    step();
    total++;
    if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== {32'h0, NOP, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset: got pcf=%h instr=%h pcd=%h p4=%h v=%b, want 0/00000013/0/0/0",
               PCF, InstrD, PCD, PCPlus4D, ValidD);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] e_pcf, e_pcd;
    idle();
    for (int i = 1; i <= 4; i++) begin
      step();
      e_pcf = 32'(4 * i);
      e_pcd = 32'(4 * (i - 1));
      total++;
      if ({PCF, PCD, PCPlus4D, InstrD, ValidD} !== {e_pcf, e_pcd, e_pcd + 32'd4, imem(e_pcd), 1'b1}) begin
        bad++;
        $display("FAIL free_run[%0d]: got pcf=%h pcd=%h p4=%h instr=%h v=%b, want pcf=%h pcd=%h p4=%h instr=%h v=1",
                 i, PCF, PCD, PCPlus4D, InstrD, ValidD, e_pcf, e_pcd, e_pcd + 32'd4, imem(e_pcd));
      end
    end
  endtask

  task automatic test_redirect_flush();
    // PCF is 0x10 here after the free run.
    PCSrcE = 1; FlushD = 1; PCTargetE = 32'h42;
    step();
    total++;
    if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== {32'h40, NOP, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL redirect_flush: got pcf=%h instr=%h pcd=%h p4=%h v=%b, want 40/00000013/0/0/0",
               PCF, InstrD, PCD, PCPlus4D, ValidD);
    end
    idle();
    step();
    total++;
    if ({PCF, PCD, PCPlus4D, InstrD, ValidD} !== {32'h44, 32'h40, 32'h44, imem(32'h40), 1'b1}) begin
      bad++;
      $display("FAIL redirect_target_d: got pcf=%h pcd=%h p4=%h instr=%h v=%b, want 44/40/44/%h/1",
               PCF, PCD, PCPlus4D, InstrD, ValidD, imem(32'h40));
    end
  endtask

  task automatic test_stall();
    PCSrcE = 1; PCTargetE = 32'h20;
    step();
    idle();
    total++;
    if ({PCF, PCD, PCPlus4D, ValidD} !== {32'h20, 32'h44, 32'h48, 1'b1}) begin
      bad++;
      $display("FAIL redirect_nofl: got pcf=%h pcd=%h p4=%h v=%b, want 20/44/48/1", PCF, PCD, PCPlus4D, ValidD);
    end
    StallF = 1; StallD = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== {32'h20, imem(32'h44), 32'h44, 32'h48, 1'b1}) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got pcf=%h instr=%h pcd=%h p4=%h v=%b, want 20/%h/44/48/1",
                 i, PCF, InstrD, PCD, PCPlus4D, ValidD, imem(32'h44));
      end
    end
    idle();
    step();
    total++;
    if ({PCF, PCD, PCPlus4D, InstrD, ValidD} !== {32'h24, 32'h20, 32'h24, imem(32'h20), 1'b1}) begin
      bad++;
      $display("FAIL stall_release: got pcf=%h pcd=%h p4=%h instr=%h v=%b, want 24/20/24/%h/1",
               PCF, PCD, PCPlus4D, InstrD, ValidD, imem(32'h20));
    end
    // StallF alone: IF/ID reloads the same PC every edge.
    StallF = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({PCF, PCD, PCPlus4D, InstrD, ValidD} !== {32'h24, 32'h24, 32'h28, imem(32'h24), 1'b1}) begin
        bad++;
        $display("FAIL stallf_only[%0d]: got pcf=%h pcd=%h p4=%h instr=%h v=%b, want 24/24/28/%h/1",
                 i, PCF, PCD, PCPlus4D, InstrD, ValidD, imem(32'h24));
      end
    end
    idle();
  endtask

  task automatic test_imem_wait();
    PCSrcE = 1; PCTargetE = 32'h30;
    step();
    idle();
    ImemReady = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== {32'h30, NOP, 32'h0, 32'h0, 1'b0}) begin
        bad++;
        $display("FAIL imem_wait[%0d]: got pcf=%h instr=%h pcd=%h p4=%h v=%b, want 30/00000013/0/0/0",
                 i, PCF, InstrD, PCD, PCPlus4D, ValidD);
      end
    end
    ImemReady = 1;
    step();
    total++;
    if ({PCF, PCD, PCPlus4D, InstrD, ValidD} !== {32'h34, 32'h30, 32'h34, imem(32'h30), 1'b1}) begin
      bad++;
      $display("FAIL imem_ready: got pcf=%h pcd=%h p4=%h instr=%h v=%b, want 34/30/34/%h/1",
               PCF, PCD, PCPlus4D, InstrD, ValidD, imem(32'h30));
    end
    // Redirect wins over StallF and ImemReady=0; IF/ID gets a bubble.
    StallF = 1; ImemReady = 0; PCSrcE = 1; PCTargetE = 32'h53;
    step();
    total++;
    if ({PCF, InstrD, PCD, ValidD} !== {32'h50, NOP, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL redirect_prio: got pcf=%h instr=%h pcd=%h v=%b, want 50/00000013/0/0", PCF, InstrD, PCD, ValidD);
    end
    idle();
  endtask

  task automatic test_wrap();
    PCSrcE = 1; PCTargetE = 32'hFFFF_FFFE;
    step();
    idle();
    total++;
    if ({PCF, PCD, PCPlus4D} !== {32'hFFFF_FFFC, 32'h50, 32'h54}) begin
      bad++;
      $display("FAIL wrap_target: got pcf=%h pcd=%h p4=%h, want fffffffc/50/54", PCF, PCD, PCPlus4D);
    end
    step();
    total++;
    if ({PCF, PCD, PCPlus4D, InstrD, ValidD} !== {32'h0, 32'hFFFF_FFFC, 32'h0, imem(32'hFFFF_FFFC), 1'b1}) begin
      bad++;
      $display("FAIL wrap: got pcf=%h pcd=%h p4=%h instr=%h v=%b, want 0/fffffffc/0/%h/1",
               PCF, PCD, PCPlus4D, InstrD, ValidD, imem(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_flush_over_stall();
    StallD = 1; FlushD = 1;
    step();
    idle();
    total++;
    if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== {32'h4, NOP, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL flush_over_stall: got pcf=%h instr=%h pcd=%h p4=%h v=%b, want 4/00000013/0/0/0",
               PCF, InstrD, PCD, PCPlus4D, ValidD);
    end
    step();
    total++;
    if ({PCF, PCD, ValidD} !== {32'h8, 32'h4, 1'b1}) begin
      bad++;
      $display("FAIL after_flush: got pcf=%h pcd=%h v=%b, want 8/4/1", PCF, PCD, ValidD);
    end
  endtask

  task automatic test_mid_reset();
    rst = 1; StallD = 1; PCSrcE = 1; PCTargetE = 32'h80;
    step();
    total++;
    if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== {32'h0, NOP, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset: got pcf=%h instr=%h pcd=%h p4=%h v=%b, want 0/00000013/0/0/0",
               PCF, InstrD, PCD, PCPlus4D, ValidD);
    end
    idle();
    step();
    total++;
    if ({PCF, PCD, PCPlus4D, InstrD, ValidD} !== {32'h4, 32'h0, 32'h4, imem(32'h0), 1'b1}) begin
      bad++;
      $display("FAIL post_reset: got pcf=%h pcd=%h p4=%h instr=%h v=%b, want 4/0/4/%h/1",
               PCF, PCD, PCPlus4D, InstrD, ValidD, imem(32'h0));
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_free_run();
    test_redirect_flush();
    test_stall();
    test_imem_wait();
    test_wrap();
    test_flush_over_stall();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
